dual_ram_fifo_ctrl: RTL and testbench
=====================================

// Module: dual_ram_fifo_ctrl
// PURPOSE
// - Synchronous FIFO controller directly upstream of the 256x8 dual-port RAM.
// - Converts a push/pop stream interface into the RAM's we/re/wr_addr/rd_addr/data_in controls.
// - Tracks occupancy and flags overflow/underflow; returns the RAM read data to the consumer with a valid strobe.
// - The RAM's own rst input is tied low by the integrator. Contents are don't-care because the controller gates every read by occupancy.
// PARAMETERS
// - RAM_WIDTH  8    data width; must match the RAM.
// - RAM_DEPTH  256  number of entries; must equal 2**ADDR_SIZE.
// - ADDR_SIZE  8    address width; must match the RAM.
// - AF_LEVEL   240  almost-full threshold (count >= AF_LEVEL). Used only with FIFO_ALMOST_FLAGS_EN.
// - AE_LEVEL   16   almost-empty threshold (count <= AE_LEVEL). Used only with FIFO_ALMOST_FLAGS_EN.
// PORTS
// - clk          in   1            single clock; all logic on posedge.
// - rst_n        in   1            asynchronous, active-low reset.
// - push         in   1            producer write request.
// - push_data    in   RAM_WIDTH    producer write data.
// - pop          in   1            consumer read request.
// - pop_data     out  RAM_WIDTH    read data; equals ram_dout (RAM output register).
// - pop_valid    out  1            pop_data holds a newly popped word this cycle.
// - full         out  1            count == RAM_DEPTH.
// - empty        out  1            count == 0.
// - count        out  ADDR_SIZE+1  current occupancy, 0..RAM_DEPTH.
// - overflow     out  1            sticky: a push was rejected.
// - underflow    out  1            sticky: a pop was rejected.
// - almost_full  out  1            present only with FIFO_ALMOST_FLAGS_EN.
// - almost_empty out  1            present only with FIFO_ALMOST_FLAGS_EN.
// - ram_we       out  1            to RAM we.
// - ram_re       out  1            to RAM re.
// - ram_wr_addr  out  ADDR_SIZE    to RAM wr_addr.
// - ram_rd_addr  out  ADDR_SIZE    to RAM rd_addr.
// - ram_din      out  RAM_WIDTH    to RAM data_in.
// - ram_dout     in   RAM_WIDTH    from RAM data_out.
// BEHAVIOUR
// - Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, overflow=0, underflow=0.
//   Reset outputs: empty=1, full=0, almost_empty=1, almost_full=0.
//   Mid-operation reset discards all stored words and cancels any pending pop_valid.
// - Accept rules:
//   wr_ok = push & (~full | pop_ok).
//   rd_ok = pop & ~empty.
// - RAM drive (combinational):
//   ram_we = wr_ok; ram_wr_addr = wr_ptr; ram_din = push_data.
//   ram_re = rd_ok; ram_rd_addr = rd_ptr.
// - Pointers advance by 1 on accept and wrap 255 -> 0 (natural ADDR_SIZE modulo).
// - count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
// - Read latency: pop accepted in cycle N -> pop_valid=1 and pop_data valid in cycle N+1.
//   pop_valid is a registered copy of rd_ok.
// - Full with push & pop in the same cycle:
//   - both are accepted and the RAM reads the old word at rd_ptr==wr_ptr before the write lands.
//   - count stays at 256.
// - Empty with push & pop in the same cycle:
//   - push is accepted; pop is rejected; underflow is set; count becomes 1.
//   - No read-through from the write port.
// - Full with push only: push is dropped, overflow is set, RAM is not written.
// - Empty with pop only: pop is dropped, underflow is set, ram_re=0, pop_valid=0 next cycle.
// - Sticky flags clear only on reset.
// - full, empty and count are registered-derived; they update the cycle after the accepting edge.
// CONFIGURATION
// - FIFO_ALMOST_FLAGS_EN defined:
//   - almost_full and almost_empty ports exist and are registered.
//   - They update with count, so they are valid the same cycle as the new count.
// - FIFO_ALMOST_FLAGS_EN undefined: both ports and their logic are absent; AF_LEVEL and AE_LEVEL are ignored.
// TESTING
// - Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop x3.
//   -> pop_valid on 3 consecutive cycles with pop_data 0x11,0x22,0x33; count 3 -> 0; empty=1.
// - Push 256 words 0x00..0xFF.
//   -> full=1, count=256. A 257th push sets overflow=1 and count stays 256.
//   Drain all -> data 0x00..0xFF in order.
// - Fill to full, then push 0xAA and pop together.
//   -> pop_data=0x00, count=256. After draining, 0xAA is the last word out.
// - Pop with FIFO empty -> underflow=1, ram_re=0, pop_valid=0.
//   Push+pop together on empty -> count=1, underflow=1.
// - Wrap: push/pop 300 words at steady state with count=2.
//   -> pointers wrap past 255, all data in order, no flags set.
// - Assert rst_n=0 mid-burst with count=50 and a pop in flight.
//   -> next cycle count=0, empty=1, pop_valid=0, overflow=0, underflow=0.
// - With FIFO_ALMOST_FLAGS_EN: push 240 -> almost_full=1; pop until count 16 -> almost_empty=1.

Source files
------------

// File: rtl/dual_ram_fifo_ctrl_if.sv
// Push/pop stream plus RAM control bundle for dual_ram_fifo_ctrl.
// almost_full/almost_empty exist only when FIFO_ALMOST_FLAGS_EN is defined.
interface dual_ram_fifo_ctrl_if #(
   parameter int RAM_WIDTH = 8,
   parameter int ADDR_SIZE = 8
);
   logic                 push;
   logic [RAM_WIDTH-1:0] push_data;
   logic                 pop;
   logic [RAM_WIDTH-1:0] pop_data;
   logic                 pop_valid;
   logic                 full;
   logic                 empty;
   logic [ADDR_SIZE:0]   count;
   logic                 overflow;
   logic                 underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic                 almost_full;
   logic                 almost_empty;
`endif
   logic                 ram_we;
   logic                 ram_re;
   logic [ADDR_SIZE-1:0] ram_wr_addr;
   logic [ADDR_SIZE-1:0] ram_rd_addr;
   logic [RAM_WIDTH-1:0] ram_din;
   logic [RAM_WIDTH-1:0] ram_dout;

   modport slave (
      input  push, push_data, pop, ram_dout,
      output pop_data, pop_valid, full, empty, count, overflow, underflow,
`ifdef FIFO_ALMOST_FLAGS_EN
             almost_full, almost_empty,
`endif
             ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_din
   );

   modport master (
      output push, push_data, pop, ram_dout,
      input  pop_data, pop_valid, full, empty, count, overflow, underflow,
`ifdef FIFO_ALMOST_FLAGS_EN
             almost_full, almost_empty,
`endif
             ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_din
   );
endinterface

// File: rtl/dual_ram_fifo_ctrl.sv
// FIFO controller in front of a 256x8 dual-port RAM with registered read output.
// Optional registered almost_full/almost_empty flags under FIFO_ALMOST_FLAGS_EN.
module dual_ram_fifo_ctrl #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AF_LEVEL  = 240,
   parameter int AE_LEVEL  = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   dual_ram_fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(RAM_DEPTH);

   logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
   logic [ADDR_SIZE:0]   count_q, count_nxt;
   logic                 full, empty, wr_ok, rd_ok;
   logic                 vld_pipe_q, ovf_q, udf_q;

   assign full  = (count_q == DEPTH);
   assign empty = (count_q == '0);
   assign rd_ok = bus.pop & ~empty;
   // A full FIFO still takes a write when a pop frees the slot in the same cycle;
   // the RAM returns the old word because its read happens before the write lands.
   assign wr_ok = bus.push & (~full | rd_ok);

   always_comb begin
      count_nxt = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_nxt = count_q + 1'b1;
         2'b01:   count_nxt = count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         vld_pipe_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         count_q    <= count_nxt;
         vld_pipe_q <= rd_ok;
         if (bus.push & ~wr_ok) ovf_q <= 1'b1;
         if (bus.pop & ~rd_ok)  udf_q <= 1'b1;
      end
   end

`ifdef FIFO_ALMOST_FLAGS_EN
   logic af_q, ae_q;

   // Computed from count_nxt so the flags line up with the registered count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (count_nxt >= (ADDR_SIZE+1)'(AF_LEVEL));
         ae_q <= (count_nxt <= (ADDR_SIZE+1)'(AE_LEVEL));
      end
   end

   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
`endif

   assign bus.ram_we      = wr_ok;
   assign bus.ram_wr_addr = wr_ptr;
   assign bus.ram_din     = bus.push_data;
   assign bus.ram_re      = rd_ok;
   assign bus.ram_rd_addr = rd_ptr;

   assign bus.pop_data  = bus.ram_dout;
   assign bus.pop_valid = vld_pipe_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = count_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
endmodule

// File: tb/tb_dual_ram_fifo_ctrl.sv
// Bench for dual_ram_fifo_ctrl: behavioural RAM plus a queue-based reference FIFO.
module tb_dual_ram_fifo_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   dual_ram_fifo_ctrl_if #(.RAM_WIDTH(8), .ADDR_SIZE(8)) bus();

   dual_ram_fifo_ctrl #(
      .RAM_WIDTH(8), .RAM_DEPTH(256), .ADDR_SIZE(8), .AF_LEVEL(240), .AE_LEVEL(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // 256x8 dual-port RAM, registered read, read-before-write on same address
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_din;
      if (bus.ram_re) bus.ram_dout <= mem[bus.ram_rd_addr];
   end

   logic [7:0] mq[$];
   logic       m_pv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0, m_we = 1'b0, m_re = 1'b0;
   logic [7:0] m_pd = 8'h00;
   logic       s_we, s_re;
   int         n_vec = 0, n_err = 0;

   function automatic logic [15:0] dut_st();
      logic [15:0] s;
      s = {2'b00, 1'b0, bus.pop_valid, bus.count, bus.full, bus.empty, bus.overflow, bus.underflow};
`ifdef FIFO_ALMOST_FLAGS_EN
      s[15:14] = {bus.almost_full, bus.almost_empty};
`endif
      return s;
   endfunction

   function automatic logic [15:0] exp_st();
      logic [15:0] s;
      int n;
      n = mq.size();
      s = {2'b00, 1'b0, m_pv, 9'(n), n == 256, n == 0, m_ovf, m_udf};
`ifdef FIFO_ALMOST_FLAGS_EN
      s[15:14] = {n >= 240, n <= 16};
`endif
      return s;
   endfunction

   // One clock: drive at negedge, update reference at posedge, return at next negedge.
   task automatic step(input logic p, input logic [7:0] d, input logic q);
      bus.push = p; bus.push_data = d; bus.pop = q;
      #1;
      s_we = bus.ram_we;
      s_re = bus.ram_re;
      m_re = q && (mq.size() != 0);
      m_we = p && ((mq.size() < 256) || m_re);
      @(posedge clk);
      m_pv = m_re;
      if (m_re) m_pd = mq.pop_front();
      if (m_we) mq.push_back(d);
      if (p && !m_we) m_ovf = 1'b1;
      if (q && !m_re) m_udf = 1'b1;
      @(negedge clk);
      bus.push = 1'b0; bus.pop = 1'b0;
   endtask

   task automatic do_reset();
      bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = 8'h00;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      mq.delete(); m_pv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = 8'h00;
      rst_n = 1'b0;
      @(negedge clk);
      mq.delete(); m_pv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      n_vec++;
      if (dut_st() !== exp_st()) begin
         n_err++; $display("FAIL reset_status: got %h expected %h", dut_st(), exp_st());
      end
      n_vec++;
      if ({bus.empty, bus.full, bus.count} !== {1'b1, 1'b0, 9'd0}) begin
         n_err++; $display("FAIL reset_flags: got e=%b f=%b c=%0d expected e=1 f=0 c=0", bus.empty, bus.full, bus.count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] seq [3];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (i < 3) step(1'b1, seq[i], 1'b0); else step(1'b0, 8'h00, 1'b1);
         n_vec++;
         if (dut_st() !== exp_st()) begin
            n_err++; $display("FAIL basic_status[%0d]: got %h expected %h", i, dut_st(), exp_st());
         end
         if (i >= 3) begin
            n_vec++;
            if (bus.pop_valid !== 1'b1 || bus.pop_data !== seq[i-3]) begin
               n_err++; $display("FAIL basic_data[%0d]: got v=%b %h expected v=1 %h", i, bus.pop_valid, bus.pop_data, seq[i-3]);
            end
         end
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b0);
      n_vec++;
      if ({bus.full, bus.count} !== {1'b1, 9'd256}) begin
         n_err++; $display("FAIL fill_full: got f=%b c=%0d expected f=1 c=256", bus.full, bus.count);
      end
      step(1'b1, 8'hEE, 1'b0);
      n_vec++;
      if ({s_we, bus.overflow, bus.count} !== {1'b0, 1'b1, 9'd256}) begin
         n_err++; $display("FAIL fill_overflow: got we=%b ovf=%b c=%0d expected we=0 ovf=1 c=256", s_we, bus.overflow, bus.count);
      end
      for (int i = 0; i < 256; i++) begin
         step(1'b0, 8'h00, 1'b1);
         n_vec++;
         if (dut_st() !== exp_st() || bus.pop_data !== m_pd || m_pd !== 8'(i)) begin
            n_err++; $display("FAIL fill_drain[%0d]: got st=%h d=%h expected st=%h d=%h", i, dut_st(), bus.pop_data, exp_st(), 8'(i));
         end
      end
   endtask

   task automatic test_full_pushpop();
      do_reset();
      for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hAA, 1'b1);
      n_vec++;
      if ({s_we, s_re, bus.pop_valid, bus.pop_data, bus.count} !== {1'b1, 1'b1, 1'b1, 8'h00, 9'd256}) begin
         n_err++; $display("FAIL full_pushpop: got we=%b re=%b v=%b d=%h c=%0d expected 1 1 1 00 256", s_we, s_re, bus.pop_valid, bus.pop_data, bus.count);
      end
      for (int i = 0; i < 256; i++) begin
         step(1'b0, 8'h00, 1'b1);
         n_vec++;
         if (dut_st() !== exp_st() || bus.pop_data !== m_pd) begin
            n_err++; $display("FAIL full_drain[%0d]: got st=%h d=%h expected st=%h d=%h", i, dut_st(), bus.pop_data, exp_st(), m_pd);
         end
      end
      n_vec++;
      if (bus.pop_data !== 8'hAA) begin
         n_err++; $display("FAIL full_last: got %h expected aa", bus.pop_data);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b0, 8'h00, 1'b1);
      n_vec++;
      if ({s_re, bus.pop_valid, bus.underflow} !== 3'b001 || dut_st() !== exp_st()) begin
         n_err++; $display("FAIL underflow_pop: got re=%b v=%b udf=%b expected re=0 v=0 udf=1", s_re, bus.pop_valid, bus.underflow);
      end
      do_reset();
      step(1'b1, 8'h5A, 1'b1);
      n_vec++;
      if ({s_we, s_re, bus.count, bus.underflow, bus.pop_valid} !== {1'b1, 1'b0, 9'd1, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL underflow_pushpop: got we=%b re=%b c=%0d udf=%b v=%b expected 1 0 1 1 0", s_we, s_re, bus.count, bus.underflow, bus.pop_valid);
      end
      step(1'b0, 8'h00, 1'b1);
      n_vec++;
      if (bus.pop_data !== 8'h5A || dut_st() !== exp_st()) begin
         n_err++; $display("FAIL underflow_after: got d=%h st=%h expected d=5a st=%h", bus.pop_data, dut_st(), exp_st());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(1'b1, 8'($urandom), 1'b0);
      step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 8'($urandom), 1'b1);
         n_vec++;
         if (dut_st() !== exp_st() || bus.pop_data !== m_pd || bus.count !== 9'd2) begin
            n_err++; $display("FAIL wrap[%0d]: got st=%h d=%h expected st=%h d=%h", i, dut_st(), bus.pop_data, exp_st(), m_pd);
         end
      end
      n_vec++;
      if ({bus.overflow, bus.underflow, bus.ram_wr_addr} !== {2'b00, 8'(302)}) begin
         n_err++; $display("FAIL wrap_end: got ovf=%b udf=%b wa=%0d expected 0 0 46", bus.overflow, bus.underflow, bus.ram_wr_addr);
      end
   endtask

   task automatic test_random();
      logic p, q;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         // alternate fill-biased and drain-biased phases to hit both ends
         if ((i / 400) % 2 == 0) begin
            p = ($urandom_range(0, 9) < 8); q = ($urandom_range(0, 9) < 3);
         end else begin
            p = ($urandom_range(0, 9) < 3); q = ($urandom_range(0, 9) < 8);
         end
         step(p, 8'($urandom), q);
         n_vec++;
         if (dut_st() !== exp_st() || {s_we, s_re} !== {m_we, m_re} || (m_pv && bus.pop_data !== m_pd)) begin
            n_err++; $display("FAIL random[%0d]: got st=%h we=%b re=%b d=%h expected st=%h we=%b re=%b d=%h",
                              i, dut_st(), s_we, s_re, bus.pop_data, exp_st(), m_we, m_re, m_pd);
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      step(1'b1, 8'h01, 1'b1);
      for (int i = 1; i < 50; i++) step(1'b1, 8'($urandom), 1'b0);
      n_vec++;
      if ({bus.count, bus.underflow} !== {9'd50, 1'b1}) begin
         n_err++; $display("FAIL midrst_pre: got c=%0d udf=%b expected c=50 udf=1", bus.count, bus.underflow);
      end
      bus.pop = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.pop = 1'b0;
      mq.delete(); m_pv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      @(negedge clk);
      n_vec++;
      if (dut_st() !== exp_st() || bus.pop_valid !== 1'b0) begin
         n_err++; $display("FAIL midrst_state: got %h expected %h", dut_st(), exp_st());
      end
      rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 8'hC3, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      n_vec++;
      if (bus.pop_data !== 8'hC3 || dut_st() !== exp_st()) begin
         n_err++; $display("FAIL midrst_after: got d=%h st=%h expected d=c3 st=%h", bus.pop_data, dut_st(), exp_st());
      end
   endtask

`ifdef FIFO_ALMOST_FLAGS_EN
   task automatic test_almost();
      do_reset();
      for (int i = 0; i < 239; i++) step(1'b1, 8'($urandom), 1'b0);
      n_vec++;
      if (bus.almost_full !== 1'b0) begin
         n_err++; $display("FAIL almost_239: got af=%b expected 0", bus.almost_full);
      end
      step(1'b1, 8'($urandom), 1'b0);
      n_vec++;
      if (bus.almost_full !== 1'b1 || bus.count !== 9'd240) begin
         n_err++; $display("FAIL almost_240: got af=%b c=%0d expected af=1 c=240", bus.almost_full, bus.count);
      end
      while (mq.size() > 17) step(1'b0, 8'h00, 1'b1);
      n_vec++;
      if (bus.almost_empty !== 1'b0) begin
         n_err++; $display("FAIL almost_17: got ae=%b expected 0", bus.almost_empty);
      end
      step(1'b0, 8'h00, 1'b1);
      n_vec++;
      if ({bus.almost_empty, bus.almost_full, bus.count} !== {1'b1, 1'b0, 9'd16}) begin
         n_err++; $display("FAIL almost_16: got ae=%b af=%b c=%0d expected 1 0 16", bus.almost_empty, bus.almost_full, bus.count);
      end
   endtask
`endif

   initial begin
      bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = 8'h00;
      @(negedge clk);
      test_reset();
      test_basic();
      test_fill_overflow();
      test_full_pushpop();
      test_underflow();
      test_wrap();
      test_random();
      test_mid_reset();
`ifdef FIFO_ALMOST_FLAGS_EN
      test_almost();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
